// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - single-bit combinational full-adder slice
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  wire w_p = x ^ y;

  assign s  = w_p ^ ci;
  assign co = (x & y) | (ci & w_p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, LSB first; SERIAL_ADDER_SUB_EN adds subtract
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  // Subtraction is a - b = a + ~b + 1, so it only changes what gets loaded.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  assign w_last = (r_cnt == LAST_BIT);

  fa_bit u_fa_bit (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs; DONE always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, then one slice result per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
          end
        end
        RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_co;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          // Counter holds at its last value so it never wraps.
          if (w_last) begin
            r_cout <= w_co;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized self-checking bench for serial_adder_ctrl
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request keeps the block busy for W+1 cycles,
  // the last of which is the done cycle where the arithmetic result appears.
  int           m_left = 0;
  logic [W:0]   m_pend = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = W + 1;
        m_sum  = '0;
        m_cout = 1'b0;
        m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) m_pend = {1'b0, a} + {1'b0, ~b} + 1'b1;
`endif
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_sum  = m_pend[W-1:0];
        m_cout = m_pend[W];
      end
    end
  end

  // Cycle-by-cycle comparison; sum/cout are only defined outside the RUN phase.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("done", 32'(done), 32'(m_left == 1));
      if (m_left <= 1) begin
        check("sum", 32'(sum), 32'(m_sum));
        check("cout", 32'(cout), 32'(m_cout));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                       input bit hold, output logic [W-1:0] rs, output logic rc);
    int nb;
    int nd;
    int dpos;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    nb = 0; nd = 0; dpos = -1; rs = '0; rc = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        dpos = i;
        rs = sum;
        rc = cout;
      end
      if (i == W + 1) check("idle_gap", 32'(busy), 32'd0);
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(nb), 32'(W + 1));
    check("done_pulses", 32'(nd), 32'd1);
    check("done_latency", 32'(dpos), 32'(W));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic [W-1:0] rs;
  logic         rc;
  logic [W:0]   exp_r;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rcin;
  int           nd_rst;

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    do_op(8'h0F, 8'h01, 1'b0, 1'b0, rs, rc);
    check("add_0f_01_sum", 32'(rs), 32'h10);
    check("add_0f_01_cout", 32'(rc), 32'd0);

    repeat (20) @(negedge clk);
    check("hold_sum", 32'(sum), 32'h10);
    check("hold_cout", 32'(cout), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_done", 32'(done), 32'd0);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc);
    check("wrap_sum", 32'(rs), 32'h00);
    check("wrap_cout", 32'(rc), 32'd1);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, rs, rc);
    check("max_sum", 32'(rs), 32'hFF);
    check("max_cout", 32'(rc), 32'd1);

    do_op(8'h21, 8'h42, 1'b0, 1'b1, rs, rc);
    check("held_start_sum", 32'(rs), 32'h63);
    check("held_start_cout", 32'(rc), 32'd0);
    wait_idle();

    @(negedge clk);
    a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    nd_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd_rst++;
    end
    check("midrst_no_done", 32'(nd_rst), 32'd0);
    rst_n = 1'b1;
    do_op(8'h03, 8'h04, 1'b0, 1'b0, rs, rc);
    check("after_rst_sum", 32'(rs), 32'h07);
    check("after_rst_cout", 32'(rc), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op(8'h05, 8'h03, 1'b0, 1'b0, rs, rc);
    check("sub_5_3_sum", 32'(rs), 32'h02);
    check("sub_5_3_cout", 32'(rc), 32'd1);
    do_op(8'h03, 8'h05, 1'b1, 1'b0, rs, rc);
    check("sub_3_5_sum", 32'(rs), 32'hFE);
    check("sub_3_5_cout", 32'(rc), 32'd0);
    sub = 1'b0;
`endif

    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rcin = 1'($urandom);
      exp_r = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      do_op(ra, rb, rcin, 1'b0, rs, rc);
      check("rand_sum", 32'(rs), 32'(exp_r[W-1:0]));
      check("rand_cout", 32'(rc), 32'(exp_r[W]));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add; sampled on a rising edge only while in IDLE.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  result; held until the next accepted start.
REQ-011 cout  output  1  final carry-out; held with sum.
REQ-012 sub  input  1  subtract select; present only when SERIAL_ADDER_SUB_EN is defined.

Function
REQ-013 The block shall compute {cout,sum} = a + b + cin using one 1-bit full-adder slice, one bit per clock, LSB first.
REQ-014 The FSM shall have the states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 IDLE->RUN on an edge with start=1: load the A and B shift registers, load the carry register with cin, clear the bit counter to 0, and clear sum/cout.
REQ-016 In RUN, each edge shall shift the slice sum bit into sum from the MSB side (sum shifts right), store the slice carry into the carry register, shift A and B right, and increment the counter.
REQ-017 RUN->DONE on the edge where the counter equals WIDTH-1; sum and cout are final on that edge.
REQ-018 DONE->IDLE unconditionally on the next edge; done=1 only while in DONE.
REQ-019 Latency: start accepted at edge k gives done=1 in the cycle following edge k+WIDTH; the minimum start-to-start spacing is WIDTH+2 cycles.
REQ-020 While busy=1, start shall be ignored and a/b/cin changes shall have no effect on the result.
REQ-021 sum and cout shall be stable from DONE until the next accepted start, including across IDLE cycles.
REQ-022 Arithmetic shall be modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout; no other flags.
REQ-023 The counter shall be $clog2(WIDTH) bits wide and shall not wrap during RUN.

Reset
REQ-024 rst_n=0 shall immediately force state=IDLE and busy=0, done=0, sum=0, cout=0, and clear the counter, carry register and shift registers.
REQ-025 Reset asserted mid-RUN shall abandon the operation with no done pulse; the first edge after release with start=1 begins a fresh operation.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN: when defined, the sub port exists and is captured with start; when sub=1, the B operand is loaded inverted and the carry register is loaded with 1 (cin ignored), so that sum = a - b and cout = 1 means no borrow.
REQ-027 When SERIAL_ADDER_SUB_EN is undefined, there is no sub port and the block performs addition only; all timing is identical in both builds.

Structure
REQ-028 A shared package serial_adder_pkg shall hold the state enum typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-029 The 1-bit slice shall be a separate combinational sub-module fa_bit (inputs x, y, ci; outputs s, co) instantiated once; all sequencing shall live in serial_adder_ctrl.

Verification (WIDTH=8)
REQ-030 Basic add: a=8'h0F, b=8'h01, cin=0, start pulse at edge k -> done in the cycle after edge k+8, sum=8'h10, cout=0; busy high for 9 cycles.
REQ-031 Wrap/carry: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 Ignored start: start held high with a and b changed during RUN -> exactly one done pulse, result from the originally captured operands, next operation begins only after IDLE.
REQ-033 Reset mid-op: rst_n low at RUN bit 4 -> all outputs 0 immediately, no done pulse; a new a=8'h03, b=8'h04 after release -> sum=8'h07.
REQ-034 SUB_EN build: a=8'h05, b=8'h03, sub=1 -> sum=8'h02, cout=1; a=8'h03, b=8'h05, sub=1 -> sum=8'hFE, cout=0.
REQ-035 Hold: after done, idle 20 cycles -> sum/cout unchanged, busy=0, done=0.
